// File: rtl/aes_decrypt_round.sv
// aes_decrypt_round: one AES-128 inverse-cipher round with a single output register.
// Datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when FINAL_ROUND=1).
// Byte b of a 128-bit word sits at [127-8b -: 8]; column c holds bytes 4c..4c+3.
module aes_decrypt_round #(
    parameter int unsigned FINAL_ROUND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic [127:0] out,
    output logic         out_valid
);

    localparam int unsigned W_BLOCK = 128;
    localparam int unsigned W_BYTE  = 8;
    localparam int unsigned N_BYTES = 16;
    localparam int unsigned N_COLS  = 4;
    localparam int unsigned W_COL   = 32;

    // Inverse S-box, entry 0 first (most significant byte of the concatenation).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // 256-entry combinational inverse S-box lookup.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    // Multiply by {02} in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // {09}, {0b}, {0d}, {0e} products built from one xtime chain.
    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // One column through the {0e,0b,0d,09} circulant; a0 is the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        o0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        o1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        o2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        o3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {o0, o1, o2, o3};
    endfunction

    logic [W_BLOCK-1:0] shift_c;
    logic [W_BLOCK-1:0] sub_c;
    logic [W_BLOCK-1:0] ark_c;
    logic [W_BLOCK-1:0] round_c;

    logic [W_BLOCK-1:0] out_d, out_q;
    logic               out_valid_d, out_valid_q;

    // InvShiftRows: s[r][c] moves to column (c+r)%4 of the same row.
    for (genvar c = 0; c < N_COLS; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            localparam int unsigned SRC = 4 * c + r;
            localparam int unsigned DST = 4 * ((c + r) % 4) + r;
            assign shift_c[W_BLOCK-1-W_BYTE*DST -: W_BYTE] = state[W_BLOCK-1-W_BYTE*SRC -: W_BYTE];
        end
    end

    // InvSubBytes on every byte.
    for (genvar b = 0; b < N_BYTES; b++) begin : g_sub
        assign sub_c[W_BLOCK-1-W_BYTE*b -: W_BYTE] = inv_sbox(shift_c[W_BLOCK-1-W_BYTE*b -: W_BYTE]);
    end

    // AddRoundKey.
    assign ark_c = sub_c ^ key;

    // InvMixColumns for full rounds; the last inverse round passes AddRoundKey straight through.
    if (FINAL_ROUND == 0) begin : g_mix
        for (genvar c = 0; c < N_COLS; c++) begin : g_mix_col
            assign round_c[W_BLOCK-1-W_COL*c -: W_COL] = inv_mix_col(ark_c[W_BLOCK-1-W_COL*c -: W_COL]);
        end
    end else begin : g_nomix
        assign round_c = ark_c;
    end

    // Next-state: capture a new result on valid input, otherwise hold data and drop valid.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = round_c;
            out_valid_d = 1'b1;
        end
    end

    // Output register with synchronous active-high reset that discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_decrypt_round.sv
// Directed bench for aes_decrypt_round: FIPS-197 inverse-cipher vectors on a full-round
// instance and a final-round instance driven from shared inputs.
module tb_aes_decrypt_round;

    logic         clk;
    logic         rst_n;
    logic [127:0] state;
    logic [127:0] key;
    logic         in_valid;
    logic [127:0] out0, out1;
    logic         out_valid0, out_valid1;

    int n_checks;
    int n_fail;

    localparam logic [127:0] ST_A  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] KEY_A = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] RES_A = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] ST_B  = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] KEY_B = 128'h47438735a41c65b9e016baf4aebf7ad2;
    localparam logic [127:0] RES_B = 128'h3e1c22c0b6fcbf768da85067f6170495;
    localparam logic [127:0] ST_C  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES_C = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [127:0] st;
        logic [127:0] k;
        logic         chk0;
        logic [127:0] exp0;
        logic         chk1;
        logic [127:0] exp1;
        logic         exp_v;
    } vec_t;

    localparam int N_VEC = 9;
    vec_t vecs[N_VEC];

    aes_decrypt_round #(.FINAL_ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .state(state), .key(key), .in_valid(in_valid),
        .out(out0), .out_valid(out_valid0)
    );

    aes_decrypt_round #(.FINAL_ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .state(state), .key(key), .in_valid(in_valid),
        .out(out1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [127:0] s, input logic [127:0] k);
        rst_n    = r;
        in_valid = v;
        state    = s;
        key      = k;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        state    = '0;
        key      = '0;

        //         rst   vld   state     key       chk0  exp0   chk1  exp1   exp_v
        vecs[0] = '{1'b1, 1'b1, ST_A,     KEY_A,    1'b1, '0,    1'b1, '0,    1'b0};
        vecs[1] = '{1'b1, 1'b1, ST_A,     KEY_A,    1'b1, '0,    1'b1, '0,    1'b0};
        vecs[2] = '{1'b0, 1'b1, ST_A,     KEY_A,    1'b1, RES_A, 1'b0, '0,    1'b1};
        vecs[3] = '{1'b0, 1'b1, ST_B,     KEY_B,    1'b1, RES_B, 1'b0, '0,    1'b1};
        vecs[4] = '{1'b0, 1'b0, rnd128(), rnd128(), 1'b1, RES_B, 1'b0, '0,    1'b0};
        vecs[5] = '{1'b0, 1'b0, rnd128(), rnd128(), 1'b1, RES_B, 1'b0, '0,    1'b0};
        vecs[6] = '{1'b0, 1'b1, ST_C,     KEY_C,    1'b0, '0,    1'b1, RES_C, 1'b1};
        vecs[7] = '{1'b0, 1'b0, rnd128(), rnd128(), 1'b0, '0,    1'b1, RES_C, 1'b0};
        vecs[8] = '{1'b0, 1'b1, ST_A,     KEY_A,    1'b1, RES_A, 1'b0, '0,    1'b1};

        for (int i = 0; i < N_VEC; i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].st, vecs[i].k);
            chk($sformatf("row%0d valid0", i), 128'(out_valid0), 128'(vecs[i].exp_v));
            chk($sformatf("row%0d valid1", i), 128'(out_valid1), 128'(vecs[i].exp_v));
            if (vecs[i].chk0) chk($sformatf("row%0d out0", i), out0, vecs[i].exp0);
            if (vecs[i].chk1) chk($sformatf("row%0d out1", i), out1, vecs[i].exp1);
        end

        // Mid-stream reset: a valid input coinciding with reset is dropped.
        step(1'b0, 1'b1, ST_A, KEY_A);
        chk("pre_rst out0", out0, RES_A);
        chk("pre_rst valid0", 128'(out_valid0), 128'(1'b1));
        step(1'b1, 1'b1, ST_B, KEY_B);
        chk("mid_rst out0", out0, '0);
        chk("mid_rst out1", out1, '0);
        chk("mid_rst valid0", 128'(out_valid0), 128'(1'b0));
        chk("mid_rst valid1", 128'(out_valid1), 128'(1'b0));
        step(1'b0, 1'b1, ST_B, KEY_B);
        chk("post_rst out0", out0, RES_B);
        chk("post_rst valid0", 128'(out_valid0), 128'(1'b1));
        step(1'b0, 1'b1, ST_C, KEY_C);
        chk("post_rst out1", out1, RES_C);
        chk("post_rst valid1", 128'(out_valid1), 128'(1'b1));
        step(1'b0, 1'b0, rnd128(), rnd128());
        chk("post_rst hold out1", out1, RES_C);
        chk("post_rst hold valid1", 128'(out_valid1), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
